// File: rtl/counter_seq_ctrl_if.sv
// Run-control and display bundle of the 3-bit counter sequencer.
// The master drives the raw controls, the slave (sequencer) drives counter and display outputs.
interface counter_seq_ctrl_if;
    logic       iStart;
    logic       iStop;
    logic       iClear;
    logic       iDir;
    logic [2:0] iLimit;
    logic       iOneShot;
    logic [2:0] oQ;
    logic [1:0] oState;
    logic       oTick;
    logic       oDone;
    logic [6:0] oDisplay;

    modport master (
        output iStart, iStop, iClear, iDir, iLimit, iOneShot,
        input  oQ, oState, oTick, oDone, oDisplay
    );

    modport slave (
        input  iStart, iStop, iClear, iDir, iLimit, iOneShot,
        output oQ, oState, oTick, oDone, oDisplay
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Run/pause/clear sequencer for a 3-bit up/down display counter with an internal
// count-rate prescaler and a combinational active-low seven-segment decoder.
module counter_seq_ctrl #(
    parameter int unsigned PRESCALE = 50_000_000
) (
    input  logic              CLK,
    input  logic              RST_n,
    counter_seq_ctrl_if.slave bus
);

    localparam int unsigned     PsW    = $clog2(PRESCALE);
    localparam logic [PsW-1:0]  PsLast = PsW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e         state_q;
    logic [2:0]     q_q;
    logic [PsW-1:0] ps_q;
    logic           tick_q;
    logic           done_q;

    // Bit 0 = start, bit 1 = stop, bit 2 = clear.
    logic [2:0] raw;
    logic [2:0] sync1_q, sync2_q, prev_q;
    logic [2:0] ev;
    logic       start_ev, stop_ev, clear_ev;

    assign raw = {bus.iClear, bus.iStop, bus.iStart};

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign ev       = sync2_q & ~prev_q;
    assign start_ev = ev[0];
    assign stop_ev  = ev[1];
    assign clear_ev = ev[2];

    // The load value on start doubles as the wrap target for both directions.
    logic [2:0] start_val;
    logic       at_term;
    logic [2:0] step_val;

    always_comb begin
        start_val = bus.iDir ? bus.iLimit : 3'd0;
        at_term   = bus.iDir ? (q_q == 3'd0) : (q_q >= bus.iLimit);
        if (at_term) begin
            step_val = start_val;
        end else if (bus.iDir) begin
            step_val = q_q - 3'd1;
        end else begin
            step_val = q_q + 3'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            ps_q    <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_ev) begin
                        state_q <= StRun;
                        q_q     <= start_val;
                        ps_q    <= '0;
                    end
                end
                StRun: begin
                    if (clear_ev) begin
                        state_q <= StIdle;
                        q_q     <= '0;
                        ps_q    <= '0;
                    end else if (stop_ev) begin
                        state_q <= StPause;
                    end else if (ps_q == PsLast) begin
                        ps_q   <= '0;
                        tick_q <= 1'b1;
                        if (at_term && bus.iOneShot) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            q_q <= step_val;
                        end
                    end else begin
                        ps_q <= ps_q + 1'b1;
                    end
                end
                StPause: begin
                    if (clear_ev) begin
                        state_q <= StIdle;
                        q_q     <= '0;
                        ps_q    <= '0;
                    end else if (start_ev) begin
                        state_q <= StRun;
                    end
                end
                StDone: begin
                    if (clear_ev) begin
                        state_q <= StIdle;
                        q_q     <= '0;
                        ps_q    <= '0;
                        done_q  <= 1'b0;
                    end else if (start_ev) begin
                        state_q <= StRun;
                        q_q     <= start_val;
                        ps_q    <= '0;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Active-low segments {g,f,e,d,c,b,a}.
    always_comb begin
        bus.oDisplay = 7'b1111111;
        case (q_q)
            3'd0: bus.oDisplay = 7'b1000000;
            3'd1: bus.oDisplay = 7'b1111001;
            3'd2: bus.oDisplay = 7'b0100100;
            3'd3: bus.oDisplay = 7'b0110000;
            3'd4: bus.oDisplay = 7'b0011001;
            3'd5: bus.oDisplay = 7'b0010010;
            3'd6: bus.oDisplay = 7'b0000010;
            3'd7: bus.oDisplay = 7'b1111000;
        endcase
    end

    assign bus.oQ     = q_q;
    assign bus.oState = state_q;
    assign bus.oTick  = tick_q;
    assign bus.oDone  = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboarded bench for counter_seq_ctrl at PRESCALE = 4: each expected count step is queued
// by the stimulus and popped by a monitor whenever oTick is seen.
module tb_counter_seq_ctrl;

    localparam logic [1:0] SIdle  = 2'b00;
    localparam logic [1:0] SRun   = 2'b01;
    localparam logic [1:0] SPause = 2'b10;
    localparam logic [1:0] SDone  = 2'b11;

    logic CLK   = 1'b0;
    logic RST_n = 1'b1;

    counter_seq_ctrl_if bus();

    counter_seq_ctrl #(
        .PRESCALE(4)
    ) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [4:0] exp_q[$];
    logic [4:0] mon_e;
    int         seq_up[7] = '{1, 2, 3, 4, 5, 0, 1};
    logic [2:0] prev_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_qs(input string name, input logic [2:0] q, input logic [1:0] st);
        check(name, 32'({bus.oQ, bus.oState}), 32'({q, st}));
    endtask

    task automatic push(input logic [2:0] q, input logic [1:0] st);
        exp_q.push_back({q, st});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One-cycle pulse; returns 1ns after the edge where the event takes effect.
    task automatic event_pulse(input logic s, input logic p, input logic c);
        bus.iStart = s;
        bus.iStop  = p;
        bus.iClear = c;
        @(posedge CLK);
        #1;
        bus.iStart = 1'b0;
        bus.iStop  = 1'b0;
        bus.iClear = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (RST_n && bus.oTick === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tick_unexpected: got tick with q=%0d state=%0d, expected none",
                         bus.oQ, bus.oState);
            end else begin
                mon_e = exp_q.pop_front();
                check("tick_step", 32'({bus.oQ, bus.oState}), 32'(mon_e));
            end
        end
    end

    initial begin
        bus.iStart   = 1'b0;
        bus.iStop    = 1'b0;
        bus.iClear   = 1'b0;
        bus.iDir     = 1'b0;
        bus.iLimit   = 3'd5;
        bus.iOneShot = 1'b0;
        #1 RST_n = 1'b0;

        // Held in reset while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            bus.iStart = i[0];
            bus.iStop  = ~i[0];
            bus.iClear = i[1];
            chk_qs("rst_q_state", 3'd0, SIdle);
            check("rst_display", 32'(bus.oDisplay), 32'(7'b1000000));
        end
        bus.iStart = 1'b0;
        bus.iStop  = 1'b0;
        bus.iClear = 1'b0;
        @(negedge CLK);
        #2 RST_n = 1'b1;
        cyc(3);

        // Up, wrap, limit 5.
        event_pulse(1'b1, 1'b0, 1'b0);
        chk_qs("start_run", 3'd0, SRun);
        prev_q = 3'd0;
        for (int i = 0; i < 7; i++) begin
            push(3'(seq_up[i]), SRun);
            cyc(3);
            check("up_hold", 32'(bus.oQ), 32'(prev_q));
            cyc(1);
            check("up_step", 32'(bus.oQ), 32'(seq_up[i]));
            check("up_tick", 32'(bus.oTick), 32'd1);
            if (seq_up[i] == 5) check("disp5", 32'(bus.oDisplay), 32'(7'b0010010));
            prev_q = 3'(seq_up[i]);
        end

        // Clear lands on the prescaler terminal cycle: no step.
        cyc(1);
        event_pulse(1'b0, 1'b0, 1'b1);
        chk_qs("clear_idle", 3'd0, SIdle);
        check("clear_no_tick", 32'(bus.oTick), 32'd0);

        // Down, one-shot, limit 3.
        bus.iLimit   = 3'd3;
        bus.iDir     = 1'b1;
        bus.iOneShot = 1'b1;
        event_pulse(1'b1, 1'b0, 1'b0);
        chk_qs("down_load", 3'd3, SRun);
        push(3'd2, SRun);
        cyc(4);
        chk_qs("down_2", 3'd2, SRun);
        push(3'd1, SRun);
        cyc(4);
        chk_qs("down_1", 3'd1, SRun);
        push(3'd0, SRun);
        cyc(4);
        chk_qs("down_0", 3'd0, SRun);
        push(3'd0, SDone);
        cyc(4);
        chk_qs("down_done", 3'd0, SDone);
        check("down_done_flag", 32'(bus.oDone), 32'd1);
        cyc(8);
        chk_qs("done_hold", 3'd0, SDone);

        // Reload from DONE, then stop while prescaler = 2.
        event_pulse(1'b1, 1'b0, 1'b0);
        chk_qs("reload", 3'd3, SRun);
        check("reload_done_low", 32'(bus.oDone), 32'd0);
        event_pulse(1'b0, 1'b1, 1'b0);
        chk_qs("pause", 3'd3, SPause);
        cyc(20);
        chk_qs("pause_hold", 3'd3, SPause);
        push(3'd2, SRun);
        event_pulse(1'b1, 1'b0, 1'b0);
        chk_qs("resume", 3'd3, SRun);
        cyc(1);
        check("resume_wait", 32'(bus.oQ), 32'd3);
        cyc(1);
        check("resume_step", 32'(bus.oQ), 32'd2);
        check("resume_tick", 32'(bus.oTick), 32'd1);

        // All three events at once.
        event_pulse(1'b1, 1'b1, 1'b1);
        chk_qs("simul_idle", 3'd0, SIdle);

        // Stop coinciding with prescaler terminal.
        bus.iLimit   = 3'd5;
        bus.iDir     = 1'b0;
        bus.iOneShot = 1'b0;
        event_pulse(1'b1, 1'b0, 1'b0);
        cyc(1);
        event_pulse(1'b0, 1'b1, 1'b0);
        chk_qs("stop_term", 3'd0, SPause);
        check("stop_term_tick", 32'(bus.oTick), 32'd0);
        cyc(5);
        chk_qs("stop_term_hold", 3'd0, SPause);
        push(3'd1, SRun);
        event_pulse(1'b1, 1'b0, 1'b0);
        chk_qs("resume_term", 3'd0, SRun);
        cyc(1);
        check("resume_term_step", 32'(bus.oQ), 32'd1);

        // Count to 6, then shrink the limit below oQ.
        bus.iLimit = 3'd7;
        for (int v = 2; v <= 6; v++) begin
            push(3'(v), SRun);
            cyc(4);
            check("climb", 32'(bus.oQ), 32'(v));
        end
        bus.iLimit = 3'd2;
        push(3'd0, SRun);
        cyc(4);
        check("shrink_wrap", 32'(bus.oQ), 32'd0);

        // Asynchronous reset mid-prescale.
        cyc(2);
        #2 RST_n = 1'b0;
        #1;
        chk_qs("midrst", 3'd0, SIdle);
        check("midrst_tick_done", 32'({bus.oTick, bus.oDone}), 32'd0);
        check("midrst_display", 32'(bus.oDisplay), 32'(7'b1000000));
        @(negedge CLK);
        #2 RST_n = 1'b1;
        cyc(1);

        // Limit 0: wrap keeps ticking at 0, one-shot enters DONE on the first step.
        bus.iLimit   = 3'd0;
        bus.iDir     = 1'b0;
        bus.iOneShot = 1'b0;
        event_pulse(1'b1, 1'b0, 1'b0);
        chk_qs("lim0_run", 3'd0, SRun);
        push(3'd0, SRun);
        push(3'd0, SRun);
        cyc(4);
        check("lim0_tick1", 32'({bus.oQ, bus.oTick}), 32'd1);
        cyc(4);
        check("lim0_tick2", 32'({bus.oQ, bus.oTick}), 32'd1);
        event_pulse(1'b0, 1'b0, 1'b1);
        chk_qs("lim0_clear", 3'd0, SIdle);
        bus.iDir     = 1'b1;
        bus.iOneShot = 1'b1;
        event_pulse(1'b1, 1'b0, 1'b0);
        chk_qs("lim0_os_run", 3'd0, SRun);
        push(3'd0, SDone);
        cyc(4);
        chk_qs("lim0_os_done", 3'd0, SDone);
        check("lim0_os_flag", 32'(bus.oDone), 32'd1);

        cyc(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
